// File: rtl/cu_pkg.sv
// Shared definitions for the main control unit: opcode values, ALU operation
// select encoding and the bundle of control strobes that the unit registers.
package cu_pkg;

    localparam int OPLEN = 7;

    localparam logic [OPLEN-1:0] OP_R      = 7'b0110011;
    localparam logic [OPLEN-1:0] OP_I      = 7'b0010011;
    localparam logic [OPLEN-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPLEN-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPLEN-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPLEN-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPLEN-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPLEN-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPLEN-1:0] OP_AUIPC  = 7'b0010111;

    // ALU operation class handed to the ALU control stage.
    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,  // address, jump and upper-immediate arithmetic
        ALU_SUB    = 2'b01,  // branch compare
        ALU_RFUNCT = 2'b10,  // decode funct3/funct7 of an R-type
        ALU_IFUNCT = 2'b11   // decode funct3 of an I-type ALU op
    } alu_op_e;

    // Every control output of the unit, registered as one word.
    typedef struct packed {
        logic    memtoreg;
        alu_op_e alu_op;
        logic    alu_src;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    pc_signal;
        logic    illegal;
    } ctrl_t;

    // All strobes low and ALU_ADD: the reset value of the control register.
    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: maps a 7-bit opcode to the full control word.
// Opcodes outside the table produce an all-quiet word with only illegal set.
module cu_decode
    import cu_pkg::*;
(
    input  logic [OPLEN-1:0] op_i,
    output ctrl_t            ctrl_o
);

    // Table lookup from opcode to control strobes.
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // ctrl_o unassigned, which would otherwise infer a latch.
        ctrl_o = CTRL_IDLE;
        case (op_i)
            OP_R: begin
                ctrl_o.alu_op    = ALU_RFUNCT;
                ctrl_o.reg_write = 1'b1;
            end
            OP_I: begin
                ctrl_o.alu_op    = ALU_IFUNCT;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_LOAD: begin
                ctrl_o.memtoreg  = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.mem_read  = 1'b1;
            end
            OP_STORE: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_o.alu_op = ALU_SUB;
                ctrl_o.branch = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.pc_signal = 1'b1;
            end
            OP_JALR: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.pc_signal = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            default: begin
                // Unknown opcode: keep every side-effecting strobe low.
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cu.sv
// Main control unit: decodes the instruction opcode and registers the
// resulting control strobes, giving one cycle of latency from op to outputs.
module cu
    import cu_pkg::*;
#(
    parameter int oplen = OPLEN  // only 7 is supported
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [oplen-1:0] op,
    output logic             memtoreg,
    output logic [1:0]       ALUOp,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             branch,
    output logic             pc_signal,
    output logic             illegal
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    cu_decode u_decode (
        .op_i   (op),
        .ctrl_o (ctrl_d)
    );

    // Control register; reset forces every output low without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so all flops
        // update together at the edge regardless of block ordering.
        if (rst) begin
            ctrl_q <= CTRL_IDLE;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign memtoreg  = ctrl_q.memtoreg;
    assign ALUOp     = ctrl_q.alu_op;
    assign ALUSrc    = ctrl_q.alu_src;
    assign RegWrite  = ctrl_q.reg_write;
    assign MemRead   = ctrl_q.mem_read;
    assign MemWrite  = ctrl_q.mem_write;
    assign branch    = ctrl_q.branch;
    assign pc_signal = ctrl_q.pc_signal;
    assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_cu.sv
// Self-checking bench for the control unit: directed scenarios followed by
// random opcodes, compared against a table-lookup reference model.
module tb_cu;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       memtoreg;
    logic [1:0] ALUOp;
    logic       ALUSrc;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       branch;
    logic       pc_signal;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    // Reference table: opcode and its row {memtoreg,ALUOp,ALUSrc,RegWrite,
    // MemRead,MemWrite,branch,pc_signal}, written straight from the decode table.
    logic [6:0] ref_op  [9];
    logic [8:0] ref_row [9];
    logic [9:0] exp_q;

    cu dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .memtoreg  (memtoreg),
        .ALUOp     (ALUOp),
        .ALUSrc    (ALUSrc),
        .RegWrite  (RegWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .branch    (branch),
        .pc_signal (pc_signal),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {row, illegal}: linear search of the table, illegal if absent.
    function automatic logic [9:0] model(input logic [6:0] v);
        for (int i = 0; i < 9; i++) begin
            if (ref_op[i] == v) return {ref_row[i], 1'b0};
        end
        return 10'b00_0000_0001;
    endfunction

    function automatic logic [9:0] observed();
        return {memtoreg, ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, branch, pc_signal, illegal};
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one opcode between edges, then check the registered result.
    task automatic step(input logic [6:0] v, input string tag);
        @(negedge clk);
        op = v;
        @(posedge clk);
        #1;
        exp_q = model(v);
        check(tag, observed(), exp_q);
    endtask

    initial begin
        ref_op[0] = 7'b0110011; ref_row[0] = 9'b0_10_0_1_0_0_0_0;
        ref_op[1] = 7'b0010011; ref_row[1] = 9'b0_11_1_1_0_0_0_0;
        ref_op[2] = 7'b0000011; ref_row[2] = 9'b1_00_1_1_1_0_0_0;
        ref_op[3] = 7'b0100011; ref_row[3] = 9'b0_00_1_0_0_1_0_0;
        ref_op[4] = 7'b1100011; ref_row[4] = 9'b0_01_0_0_0_0_1_0;
        ref_op[5] = 7'b1101111; ref_row[5] = 9'b0_00_0_1_0_0_0_1;
        ref_op[6] = 7'b1100111; ref_row[6] = 9'b0_00_1_1_0_0_0_1;
        ref_op[7] = 7'b0110111; ref_row[7] = 9'b0_00_1_1_0_0_0_0;
        ref_op[8] = 7'b0010111; ref_row[8] = 9'b0_00_1_1_0_0_0_0;

        // Reset asserted with a legal opcode on the input.
        rst = 1'b0;
        op  = 7'b0110011;
        #1 rst = 1'b1;
        #1;
        check("reset_async", observed(), 10'b0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", observed(), 10'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_before_edge", observed(), 10'b0);
        @(posedge clk);
        #1;
        check("first_edge_after_reset", observed(), 10'b0_10_0_1_0_0_0_0_0);

        // Directed opcode sequence, with hand-written expectations first.
        step(7'b0010011, "i_alu");
        check("i_alu_const", observed(), 10'b0_11_1_1_0_0_0_0_0);
        step(7'b0110011, "r_type");
        step(7'b0000011, "load");
        check("load_const", observed(), 10'b1_00_1_1_1_0_0_0_0);
        step(7'b0100011, "store");
        check("store_const", observed(), 10'b0_00_1_0_0_1_0_0_0);
        step(7'b1100011, "branch");
        step(7'b1101111, "jal");
        step(7'b1100111, "jalr");
        step(7'b0000000, "illegal_zero");
        check("illegal_zero_const", observed(), 10'b0_00_0_0_0_0_0_0_1);
        step(7'b1111111, "illegal_ones");
        step(7'b0110001, "illegal_low_bits");
        step(7'b0110111, "lui");
        check("lui_const", observed(), 10'b0_00_1_1_0_0_0_0_0);
        step(7'b0010111, "auipc");

        // Latency: an opcode change between edges must not reach the outputs.
        @(negedge clk);
        op = 7'b1100011;
        #2;
        check("hold_between_edges", observed(), exp_q);
        @(posedge clk);
        #1;
        exp_q = model(op);
        check("update_on_edge", observed(), exp_q);

        // Reset pulse mid-stream discards the pending opcode.
        @(negedge clk);
        op = 7'b0000011;
        #1 rst = 1'b1;
        #1;
        check("midstream_reset", observed(), 10'b0);
        @(posedge clk);
        #1;
        check("midstream_reset_edge", observed(), 10'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q = model(op);
        check("after_midstream_reset", observed(), exp_q);

        // Random opcodes: half drawn from the table, half arbitrary.
        for (int n = 0; n < 200; n++) begin
            logic [6:0] v;
            if ($urandom_range(1, 0) == 1) v = ref_op[$urandom_range(8, 0)];
            else v = 7'($urandom);
            step(v, "random");
            check("rand_mem_exclusive", {9'b0, MemRead & MemWrite}, 10'b0);
            check("rand_pc_exclusive", {9'b0, branch & pc_signal}, 10'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
